// File: rtl/pc.sv
// Program counter: reset, load of a jump/branch target, or increment,
// with a one-cycle flag marking the increment that wraps to zero.
//
// Ports:
//   pc_clk  - clock; all state changes on the rising edge
//   pc_rst  - synchronous active-high reset (highest priority)
//   pc_enb  - 1 loads pc_in, 0 increments
//   pc_in   - jump/branch target address
//   pc_out  - registered program-counter value
//   pc_next - value pc_out will take at the next rising edge
//   pc_wrap - registered; high for one cycle after an all-ones increment
module pc #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             pc_clk,
    input  logic             pc_rst,
    input  logic             pc_enb,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_wrap
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             wrap_q;
    logic             wrap_d;

    // Priority: reset, then load, then increment.
    // Only an increment from all-ones raises the wrap flag; a load of
    // all-ones does not, so the flag marks real counter overflow.
    always_comb begin
        pc_d   = pc_q + WIDTH'(1);
        wrap_d = &pc_q;
        if (pc_rst) begin
            pc_d   = RESET_VAL;
            wrap_d = 1'b0;
        end else if (pc_enb) begin
            pc_d   = pc_in;
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge pc_clk) begin
        pc_q   <= pc_d;
        wrap_q <= wrap_d;
    end

    assign pc_out  = pc_q;
    assign pc_next = pc_d;
    assign pc_wrap = wrap_q;

endmodule

// File: tb/tb_pc.sv
// Randomized and directed bench for pc with a queue-based scoreboard
// fed by the driver and drained by an independent monitor.
module tb_pc;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;
    localparam int RV  = 0;

    typedef struct {
        int pc;
        bit wrap;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         enb;
    logic [W-1:0] din;
    logic [W-1:0] pc_out;
    logic [W-1:0] pc_next;
    logic         pc_wrap;

    exp_t exp_q[$];
    int   checks;
    int   passed;
    int   m_pc;
    bit   m_wrap;
    bit   m_known;
    bit   done;

    pc #(.WIDTH(W), .RESET_VAL(W'(RV))) dut (
        .pc_clk (clk),
        .pc_rst (rst),
        .pc_enb (enb),
        .pc_in  (din),
        .pc_out (pc_out),
        .pc_next(pc_next),
        .pc_wrap(pc_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, req, $time);
    endtask

    // Reference: what the counter should hold after the coming edge.
    function automatic exp_t predict(input bit r, input bit e,
                                     input int target);
        exp_t x;
        if (r) begin
            x.pc = RV; x.wrap = 0;
        end else if (e) begin
            x.pc = target; x.wrap = 0;
        end else begin
            x.pc   = (m_pc + 1) % (MAX + 1);
            x.wrap = (m_pc == MAX);
        end
        return x;
    endfunction

    // Drive between edges, check that nothing registered moved and
    // that pc_next already shows the coming value, then enqueue it.
    task automatic step(input bit r, input bit e, input int target);
        exp_t x;
        @(negedge clk);
        rst = r; enb = e; din = W'(target);
        #1;
        if (m_known) begin
            check("pc_out_hold", int'(pc_out), m_pc);
            check("pc_wrap_hold", int'(pc_wrap), int'(m_wrap));
        end
        if (m_known || r) begin
            x = predict(r, e, target);
            check("pc_next", int'(pc_next), x.pc);
            exp_q.push_back(x);
            m_pc = x.pc; m_wrap = x.wrap; m_known = 1;
        end
    endtask

    // Monitor: after each rising edge compare against the oldest entry.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("pc_out", int'(pc_out), x.pc);
                check("pc_wrap", int'(pc_wrap), int'(x.wrap));
            end
        end
    end

    initial begin
        checks = 0; passed = 0; m_known = 0; m_pc = 0; m_wrap = 0;
        done = 0;
        rst = 1'b0; enb = 1'b0; din = '0;

        // Reset with stray inputs, then count 1..4.
        step(1, 0, 15);
        repeat (4) step(0, 0, 0);
        // Load C twice, then increment with pc_in ignored.
        step(0, 1, 12);
        step(0, 1, 12);
        step(0, 0, 15);
        step(0, 0, 15);
        // E -> F -> 0 (wrap) -> 1.
        repeat (3) step(0, 0, 0);
        // Mid-count reset while a load is requested.
        step(0, 0, 0);
        step(1, 1, 9);
        step(0, 0, 0);
        // Load all-ones, then wrap from it.
        step(0, 1, 15);
        step(0, 0, 0);
        step(0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            bit r;
            bit e;
            int t;
            r = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 3) == 0) ? MAX : $urandom_range(0, MAX);
            step(r, e, t);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        done = 1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
        end
    end

endmodule
